// File: rtl/seg_scan_pkg.sv
// Shared stopwatch display constants and types for the digit scanner.
package seg_scan_pkg;
  localparam int unsigned NDIG  = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7f;
  localparam logic [NDIG-1:0]  AN_OFF    = 4'b1111;

  typedef enum logic {
    ST_BLANK,
    ST_LIT
  } slot_st_e;

  typedef logic [1:0] dig_t;
endpackage

// File: rtl/seg_scan_div.sv
// Modulo-N free-running counter with synchronous reset and a wrap tick.
module seg_scan_div #(
  parameter  int unsigned N = 2,
  localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] cnt,
  output logic         tick
);
  assign tick = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) cnt <= '0;
    else             cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 4-digit common-anode 7-segment driver with frame capture,
// per-slot anti-ghost blanking, hold blink and run colon.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int unsigned SPN = 24_000_000,
  parameter int unsigned DPN = 24_000,
  parameter int unsigned BLK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] sec_0,
  input  logic [SEG_W-1:0] sec_1,
  input  logic [SEG_W-1:0] min_0,
  input  logic [SEG_W-1:0] min_1,
  input  logic             s_run,
  input  logic             s_hld,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic [NDIG-1:0]  an
);
  localparam int unsigned SW = (DPN > 1) ? $clog2(DPN) : 1;
  localparam int unsigned BW = (SPN > 1) ? $clog2(SPN) : 1;

  logic [SW-1:0] slot_cnt;
  logic          slot_wrap;
  logic [BW-1:0] blk_cnt;
  logic          blk_wrap;
  dig_t          dig;
  logic          on_phase;

  logic [NDIG-1:0][SEG_W-1:0] shd_pat;
  logic                       shd_run;
  logic                       shd_hld;
  slot_st_e                   st;

  seg_scan_div #(.N(DPN)) u_slot (
    .clk  (clk),
    .rst  (rst),
    .cnt  (slot_cnt),
    .tick (slot_wrap)
  );

  seg_scan_div #(.N(SPN)) u_blink (
    .clk  (clk),
    .rst  (rst),
    .cnt  (blk_cnt),
    .tick (blk_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst)            dig <= '0;
    else if (slot_wrap) dig <= dig + 1'b1;
  end

  // on_phase tracks (blk_cnt < SPN/2): set as blk_cnt returns to 0, cleared as it reaches SPN/2
  always_ff @(posedge clk) begin
    if (rst || blk_wrap)                    on_phase <= 1'b1;
    else if (blk_cnt == BW'(SPN / 2 - 1))   on_phase <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shd_pat <= '0;
      shd_run <= 1'b0;
      shd_hld <= 1'b0;
    end else if (slot_cnt == '0 && dig == '0) begin
      shd_pat <= {min_1, min_0, sec_1, sec_0};
      shd_run <= s_run;
      shd_hld <= s_hld;
    end
  end

  always_comb begin
    st = ST_LIT;
    if (slot_cnt < SW'(BLK) || (shd_hld && !on_phase)) st = ST_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst || st == ST_BLANK) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NDIG'(1) << dig);
      seg <= ~shd_pat[dig];
      dp  <= !(dig == 2'd2 && shd_run && on_phase);
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: arithmetic reference model feeds a queue, monitor compares.
module tb_seg_scan;
  localparam int unsigned SPN = 240;
  localparam int unsigned DPN = 8;
  localparam int unsigned BLK = 2;
  localparam int unsigned FRM = 4 * DPN;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [6:0] sec_0, sec_1, min_0, min_1;
  logic       s_run, s_hld;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  exp_t        q[$];
  int unsigned total;
  int unsigned bad;
  bit          done;

  // reference model state: n = index of the next non-reset edge since reset release
  int unsigned n;
  logic [6:0]  m_pat[4];
  logic        m_run, m_hld;

  seg_scan #(.SPN(SPN), .DPN(DPN), .BLK(BLK)) dut (
    .clk   (clk),
    .rst   (rst),
    .sec_0 (sec_0),
    .sec_1 (sec_1),
    .min_0 (min_0),
    .min_1 (min_1),
    .s_run (s_run),
    .s_hld (s_hld),
    .seg   (seg),
    .dp    (dp),
    .an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic r);
    exp_t        e;
    int unsigned slot, d, b;
    bit          on, blank;
    rst = r;
    e = '{an: 4'hf, seg: 7'h7f, dp: 1'b1};
    if (r) begin
      n     = 0;
      m_pat = '{default: '0};
      m_run = 1'b0;
      m_hld = 1'b0;
    end else begin
      slot  = n % DPN;
      d     = (n / DPN) % 4;
      b     = n % SPN;
      on    = (b < SPN / 2);
      blank = (slot < BLK) || (m_hld && !on);
      if (!blank) begin
        e.an  = ~(4'b0001 << d);
        e.seg = ~m_pat[d];
        e.dp  = !(d == 2 && m_run && on);
      end
      if (n % FRM == 0) begin
        m_pat[0] = sec_0;
        m_pat[1] = sec_1;
        m_pat[2] = min_0;
        m_pat[3] = min_1;
        m_run    = s_run;
        m_hld    = s_hld;
      end
      n++;
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic goto_phase(input int unsigned p);
    for (int k = 0; k < 2 * FRM && (n % FRM) != p; k++) cyc(1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow t=%0t: no expected entry for DUT output", $time);
      end else begin
        e = q.pop_front();
        if ({an, seg, dp} !== e) begin
          bad++;
          $display("FAIL scan t=%0t an=%b/%b seg=%h/%h dp=%b/%b (got/exp)",
                   $time, an, e.an, seg, e.seg, dp, e.dp);
        end
      end
    end
  end

  initial begin : driver
    done  = 1'b0;
    total = 0;
    bad   = 0;
    sec_0 = '0; sec_1 = '0; min_0 = '0; min_1 = '0;
    s_run = 1'b0; s_hld = 1'b0;

    repeat (3) cyc(1'b1);

    sec_0 = 7'h3f; sec_1 = 7'h06; min_0 = 7'h5b; min_1 = 7'h4f;
    repeat (2 * FRM) cyc(1'b0);

    // change sec_0 inside the dig=2 slot; must not appear until next frame
    goto_phase(2 * DPN);
    repeat (3) cyc(1'b0);
    sec_0 = 7'h06;
    repeat (FRM + DPN) cyc(1'b0);

    s_run = 1'b1;
    repeat (2 * SPN) cyc(1'b0);
    s_hld = 1'b1;
    repeat (2 * SPN) cyc(1'b0);
    s_run = 1'b0;
    repeat (SPN) cyc(1'b0);
    s_hld = 1'b0;
    s_run = 1'b1;
    repeat (FRM) cyc(1'b0);

    // single-cycle reset in the dig=3 LIT phase
    goto_phase(3 * DPN + 4);
    cyc(1'b1);
    repeat (SPN + FRM) cyc(1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: sec_0 = 7'($urandom);
          1: sec_1 = 7'($urandom);
          2: min_0 = 7'($urandom);
          default: min_1 = 7'($urandom);
        endcase
      end
      if ($urandom_range(0, 199) == 0) s_run = ~s_run;
      if ($urandom_range(0, 299) == 0) s_hld = ~s_hld;
      cyc(($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0);
    end

    done = 1'b1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d entries remain, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
